// File: rtl/move_writer_pkg.sv
// Shared definitions for the paper-soccer move commit engine:
// direction codes, FSM encoding and board addressing helpers.
package move_writer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] DIR_A = 3'd0;
  localparam logic [2:0] DIR_B = 3'd1;
  localparam logic [2:0] DIR_C = 3'd2;
  localparam logic [2:0] DIR_D = 3'd3;
  localparam logic [2:0] DIR_E = 3'd4;
  localparam logic [2:0] DIR_F = 3'd5;
  localparam logic [2:0] DIR_G = 3'd6;
  localparam logic [2:0] DIR_H = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    CALC,
    RD_SRC,
    CHK_SRC,
    WR_SRC,
    RD_DST,
    CHK_DST,
    WR_DST,
    DONE
  } state_t;

  function automatic logic [2:0] opposite(input logic [2:0] dir);
    return dir ^ 3'd4;
  endfunction

  // Row-major board address; 255*255+255 still fits in 16 bits.
  function automatic logic [15:0] board_addr(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic [7:0] width);
    return (16'(y) * 16'(width)) + 16'(x);
  endfunction

endpackage

// File: rtl/move_writer_dir_offset.sv
// Maps a 3-bit move direction to two's-complement 2-bit dx/dy steps.
module dir_offset
  import move_writer_pkg::*;
(
  input  logic [2:0] dir,
  output logic [1:0] dx,
  output logic [1:0] dy
);

  always_comb begin
    dx = 2'b00;
    dy = 2'b00;
    case (dir)
      DIR_A: begin dx = 2'b00; dy = 2'b11; end
      DIR_B: begin dx = 2'b01; dy = 2'b11; end
      DIR_C: begin dx = 2'b01; dy = 2'b00; end
      DIR_D: begin dx = 2'b01; dy = 2'b01; end
      DIR_E: begin dx = 2'b00; dy = 2'b01; end
      DIR_F: begin dx = 2'b11; dy = 2'b01; end
      DIR_G: begin dx = 2'b11; dy = 2'b00; end
      DIR_H: begin dx = 2'b11; dy = 2'b11; end
      default: begin dx = 2'b00; dy = 2'b00; end
    endcase
  end

endmodule

// File: rtl/move_writer.sv
// Move commit engine: validates one move and draws its edge at both
// endpoints of the board memory with read-modify-write.
module move_writer
  import move_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dir_in,
  input  logic        dir_valid,
  input  logic [7:0]  cur_x_in,
  input  logic [7:0]  cur_y_in,
  input  logic [7:0]  width_in,
  input  logic [7:0]  length_in,
  output logic        ready,
  output logic        done,
  output logic        illegal,
  output logic        bounce,
  output logic [7:0]  new_x,
  output logic [7:0]  new_y,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  state_t state, state_next;

  logic [2:0]        dir_q;
  logic [7:0]        src_x, src_y, width_q, length_q;
  logic [7:0]        dst_x, dst_y;
  logic [BYTE_W-1:0] src_byte, dst_byte;
  logic              bounce_pend;

  logic [1:0]  dx, dy;
  logic [8:0]  calc_x, calc_y;
  logic        out_of_bounds, dup_edge, dst_border;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  dir_bit, opp_bit;

  dir_offset u_dir_offset (
    .dir (dir_q),
    .dx  (dx),
    .dy  (dy)
  );

  // Bit 8 set after a signed step means the coordinate went below zero.
  assign calc_x        = {1'b0, src_x} + {{7{dx[1]}}, dx};
  assign calc_y        = {1'b0, src_y} + {{7{dy[1]}}, dy};
  assign out_of_bounds = calc_x[8] | calc_y[8] |
                         (calc_x[7:0] >= width_q) | (calc_y[7:0] >= length_q);
  assign dup_edge      = mem_rdata[dir_q];
  assign dst_border    = (dst_x == 8'd0) | (dst_x == width_q - 8'd1) |
                         (dst_y == 8'd0) | (dst_y == length_q - 8'd1);
  assign src_addr      = board_addr(src_x, src_y, width_q);
  assign dst_addr      = board_addr(dst_x, dst_y, width_q);
  assign dir_bit       = 8'd1 << dir_q;
  assign opp_bit       = 8'd1 << opposite(dir_q);

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 8'd0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (dir_valid) state_next = CALC;
      end
      CALC:    state_next = out_of_bounds ? DONE : RD_SRC;
      RD_SRC: begin
        mem_addr   = src_addr;
        state_next = CHK_SRC;
      end
      CHK_SRC: state_next = dup_edge ? DONE : WR_SRC;
      WR_SRC: begin
        mem_addr   = src_addr;
        mem_wdata  = src_byte | dir_bit;
        mem_we     = 1'b1;
        state_next = RD_DST;
      end
      RD_DST: begin
        mem_addr   = dst_addr;
        state_next = CHK_DST;
      end
      CHK_DST: state_next = WR_DST;
      WR_DST: begin
        mem_addr   = dst_addr;
        mem_wdata  = dst_byte | opp_bit;
        mem_we     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change on the edge that enters DONE, so they
  // stay stable for the consumer until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dir_q       <= 3'd0;
      src_x       <= 8'd0;
      src_y       <= 8'd0;
      width_q     <= 8'd0;
      length_q    <= 8'd0;
      dst_x       <= 8'd0;
      dst_y       <= 8'd0;
      src_byte    <= 8'd0;
      dst_byte    <= 8'd0;
      bounce_pend <= 1'b0;
      illegal     <= 1'b0;
      bounce      <= 1'b0;
      new_x       <= 8'd0;
      new_y       <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dir_valid) begin
            dir_q    <= dir_in;
            src_x    <= cur_x_in;
            src_y    <= cur_y_in;
            width_q  <= width_in;
            length_q <= length_in;
          end
        end
        CALC: begin
          dst_x <= calc_x[7:0];
          dst_y <= calc_y[7:0];
          if (out_of_bounds) begin
            illegal <= 1'b1;
            bounce  <= 1'b0;
          end
        end
        CHK_SRC: begin
          src_byte <= mem_rdata;
          if (dup_edge) begin
            illegal <= 1'b1;
            bounce  <= 1'b0;
          end
        end
        CHK_DST: begin
          dst_byte    <= mem_rdata;
          bounce_pend <= (mem_rdata != 8'd0) | dst_border;
        end
        WR_DST: begin
          illegal <= 1'b0;
          bounce  <= bounce_pend;
          new_x   <= dst_x;
          new_y   <= dst_y;
        end
        default: ;
      endcase
    end
  end

endmodule
